// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: shared state encodings, widths and helpers for the interrupt controller
package interrupt_controller_pkg;
  localparam int INTC_ID_W   = 3;
  localparam int INTC_ADDR_W = 16;
  typedef enum logic [1:0] {
    INTC_IDLE = 2'd0,
    INTC_REQ  = 2'd1,
    INTC_SVC  = 2'd2
  } intc_state_e;
  function automatic logic [7:0] intc_onehot(input logic [INTC_ID_W-1:0] idx);
    return 8'd1 << idx;
  endfunction
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: 8-bit lowest-index-wins priority encoder
module intc_prio_enc
  import interrupt_controller_pkg::*;
(
  input  logic [7:0]           req_i,
  output logic                 valid_o,
  output logic [INTC_ID_W-1:0] idx_o
);
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    for (int i = 7; i >= 0; i--) idx_o = req_i[i] ? INTC_ID_W'(i) : idx_o;
  end
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: prioritised maskable IRQ controller with req/ack/eoi handshake.
// Define INTC_NESTING_EN to let higher-priority sources preempt a handler in service.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int               NUM_IRQ      = 8,
  parameter logic [7:0]       MASK_RESET   = 8'hFF,
  parameter logic [15:0]      VECTOR_BASE  = 16'h0010,
  parameter int               VECTOR_SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_IRQ-1:0]     irq_in,
  input  logic                   mask_we,
  input  logic [7:0]             mask_wdata,
  output logic [7:0]             mask_o,
  output logic [7:0]             pending_o,
  output logic                   int_req,
  output logic [INTC_ID_W-1:0]   int_id,
  output logic [INTC_ADDR_W-1:0] int_vector,
  input  logic                   int_ack,
  input  logic                   int_eoi
);
  localparam logic [7:0] VALID = 8'((9'd1 << NUM_IRQ) - 9'd1);
  intc_state_e state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [7:0] pending_q, pending_d, mask_q, mask_d, in_svc_q, in_svc_d, edges;
  logic [INTC_ID_W-1:0] id_q, id_d, cand_idx, hs_idx;
  logic [INTC_ADDR_W-1:0] vec_q, vec_d;
  logic req_q, cand_valid, hs_valid, ack, eoi, nest, load;
  intc_prio_enc u_cand (.req_i(pending_q & mask_q), .valid_o(cand_valid), .idx_o(cand_idx));
  intc_prio_enc u_hs (.req_i(in_svc_q), .valid_o(hs_valid), .idx_o(hs_idx));
`ifdef INTC_NESTING_EN
  assign nest = cand_valid && (cand_idx < hs_idx);
`else
  assign nest = 1'b0;
`endif
  assign edges = 8'(irq_in & ~irq_prev_q);
  assign ack = (state_q == INTC_REQ) && int_ack;
  assign eoi = (state_q == INTC_SVC) && int_eoi && hs_valid;
  always_comb begin
    pending_d = (pending_q & ~(ack ? intc_onehot(id_q) : 8'd0)) | edges;
    in_svc_d = (in_svc_q | (ack ? intc_onehot(id_q) : 8'd0)) & ~(eoi ? intc_onehot(hs_idx) : 8'd0);
    mask_d = mask_we ? (mask_wdata & VALID) : mask_q;
    state_d = state_q == INTC_IDLE ? (cand_valid ? INTC_REQ : INTC_IDLE)
            : state_q == INTC_REQ  ? (ack ? INTC_SVC : INTC_REQ)
            : state_q == INTC_SVC  ? (eoi ? (|in_svc_d ? INTC_SVC : INTC_IDLE) : nest ? INTC_REQ : INTC_SVC)
            : INTC_IDLE;
    // id and vector freeze for the whole request once latched on REQ entry
    load = (state_d == INTC_REQ) && (state_q != INTC_REQ);
    id_d = load ? cand_idx : id_q;
    vec_d = load ? VECTOR_BASE + (INTC_ADDR_W'(cand_idx) << VECTOR_SHIFT) : vec_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INTC_IDLE;
      irq_prev_q <= '0;
      pending_q <= '0;
      mask_q <= MASK_RESET & VALID;
      in_svc_q <= '0;
      id_q <= '0;
      vec_q <= VECTOR_BASE;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_prev_q <= irq_in;
      pending_q <= pending_d;
      mask_q <= mask_d;
      in_svc_q <= in_svc_d;
      id_q <= id_d;
      vec_q <= vec_d;
      req_q <= state_d == INTC_REQ;
    end
  end
  assign mask_o = mask_q;
  assign pending_o = pending_q;
  assign int_req = req_q;
  assign int_id = id_q;
  assign int_vector = vec_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: table-driven, scoreboarded check of the interrupt controller
module tb_interrupt_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] irq_in = '0, mask_wdata = '0;
  logic mask_we = 1'b0, int_ack = 1'b0, int_eoi = 1'b0;
  logic [7:0] mask_o, pending_o;
  logic int_req;
  logic [2:0] int_id;
  logic [15:0] int_vector;
  typedef struct {
    logic [7:0] irq;
    logic mwe;
    logic [7:0] md;
    logic ack, eoi, req;
    logic [2:0] id;
    logic [7:0] pend, mask;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  int checks = 0, errors = 0;

  interrupt_controller dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .mask_o(mask_o), .pending_o(pending_o), .int_req(int_req), .int_id(int_id),
    .int_vector(int_vector), .int_ack(int_ack), .int_eoi(int_eoi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic void r(input logic [7:0] irq, input logic mwe, input logic [7:0] md,
                            input logic ack, input logic eoi, input logic req,
                            input logic [2:0] id, input logic [7:0] pend, input logic [7:0] mask);
    tbl.push_back('{irq, mwe, md, ack, eoi, req, id, pend, mask});
  endfunction

  task automatic apply(input int i, input vec_t v);
    vec_t e;
    irq_in = v.irq; mask_we = v.mwe; mask_wdata = v.md; int_ack = v.ack; int_eoi = v.eoi;
    sb.push_back(v);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk($sformatf("row%0d req", i), 32'(int_req), 32'(e.req));
    chk($sformatf("row%0d id", i), 32'(int_id), 32'(e.id));
    chk($sformatf("row%0d vector", i), 32'(int_vector), 32'(16'h0010 + (16'(e.id) << 2)));
    chk($sformatf("row%0d pending", i), 32'(pending_o), 32'(e.pend));
    chk($sformatf("row%0d mask", i), 32'(mask_o), 32'(e.mask));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset mask", 32'(mask_o), 32'hFF);
    chk("reset pending", 32'(pending_o), 32'h0);
    chk("reset req", 32'(int_req), 32'h0);
    chk("reset vector", 32'(int_vector), 32'h0010);
    reset = 1'b0;
    // single event on irq 3
    r(8'h08,0,0,0,0, 0,0,8'h08,8'hFF);
    r(8'h00,0,0,0,0, 1,3,8'h08,8'hFF);
    r(8'h00,0,0,0,0, 1,3,8'h08,8'hFF);
    r(8'h00,0,0,1,0, 0,3,8'h00,8'hFF);
    r(8'h00,0,0,0,1, 0,3,8'h00,8'hFF);
    r(8'h00,0,0,0,0, 0,3,8'h00,8'hFF);
    // priority: 5 and 1 together
    r(8'h22,0,0,0,0, 0,3,8'h22,8'hFF);
    r(8'h00,0,0,0,0, 1,1,8'h22,8'hFF);
    r(8'h00,0,0,1,0, 0,1,8'h20,8'hFF);
    r(8'h00,0,0,0,1, 0,1,8'h20,8'hFF);
    r(8'h00,0,0,0,0, 1,5,8'h20,8'hFF);
    r(8'h00,0,0,1,0, 0,5,8'h00,8'hFF);
    r(8'h00,0,0,0,1, 0,5,8'h00,8'hFF);
    // mask gates selection only; selection on the write edge uses the old mask
    r(8'h00,1,8'hFD,0,0, 0,5,8'h00,8'hFD);
    r(8'h02,0,0,0,0, 0,5,8'h02,8'hFD);
    r(8'h00,0,0,0,0, 0,5,8'h02,8'hFD);
    r(8'h00,0,0,0,0, 0,5,8'h02,8'hFD);
    r(8'h00,1,8'hFF,0,0, 0,5,8'h02,8'hFF);
    r(8'h00,0,0,0,0, 1,1,8'h02,8'hFF);
    r(8'h00,0,0,1,0, 0,1,8'h00,8'hFF);
    r(8'h00,0,0,0,1, 0,1,8'h00,8'hFF);
    // set beats clear on id 2
    r(8'h04,0,0,0,0, 0,1,8'h04,8'hFF);
    r(8'h00,0,0,0,0, 1,2,8'h04,8'hFF);
    r(8'h04,0,0,1,0, 0,2,8'h04,8'hFF);
    r(8'h00,0,0,0,1, 0,2,8'h04,8'hFF);
    r(8'h00,0,0,0,0, 1,2,8'h04,8'hFF);
    r(8'h00,0,0,1,0, 0,2,8'h00,8'hFF);
    r(8'h00,0,0,0,1, 0,2,8'h00,8'hFF);
    // ack/eoi in IDLE ignored; ack+eoi together: eoi dropped
    r(8'h00,0,0,1,1, 0,2,8'h00,8'hFF);
    r(8'h01,0,0,0,0, 0,2,8'h01,8'hFF);
    r(8'h00,0,0,0,0, 1,0,8'h01,8'hFF);
    r(8'h00,0,0,1,1, 0,0,8'h00,8'hFF);
    r(8'h00,0,0,0,0, 0,0,8'h00,8'hFF);
    r(8'h02,0,0,0,0, 0,0,8'h02,8'hFF);
    r(8'h00,0,0,0,0, 0,0,8'h02,8'hFF);
    r(8'h00,0,0,0,1, 0,0,8'h02,8'hFF);
    r(8'h00,0,0,0,0, 1,1,8'h02,8'hFF);
    r(8'h00,0,0,1,0, 0,1,8'h00,8'hFF);
    r(8'h00,0,0,0,1, 0,1,8'h00,8'hFF);
    // a held level produces a single event
    r(8'h10,0,0,0,0, 0,1,8'h10,8'hFF);
    r(8'h10,0,0,0,0, 1,4,8'h10,8'hFF);
    r(8'h10,0,0,1,0, 0,4,8'h00,8'hFF);
    r(8'h10,0,0,0,1, 0,4,8'h00,8'hFF);
    r(8'h00,0,0,0,0, 0,4,8'h00,8'hFF);
    // irq 0 arrives while id 4 is in service
    r(8'h10,0,0,0,0, 0,4,8'h10,8'hFF);
    r(8'h00,0,0,0,0, 1,4,8'h10,8'hFF);
    r(8'h00,0,0,1,0, 0,4,8'h00,8'hFF);
    r(8'h01,0,0,0,0, 0,4,8'h01,8'hFF);
`ifdef INTC_NESTING_EN
    r(8'h00,0,0,0,0, 1,0,8'h01,8'hFF);
    r(8'h00,0,0,1,0, 0,0,8'h00,8'hFF);
    r(8'h00,0,0,0,1, 0,0,8'h00,8'hFF);
    r(8'h00,0,0,0,1, 0,0,8'h00,8'hFF);
    r(8'h00,0,0,0,0, 0,0,8'h00,8'hFF);
`else
    r(8'h00,0,0,0,0, 0,4,8'h01,8'hFF);
    r(8'h00,0,0,1,0, 0,4,8'h01,8'hFF);
    r(8'h00,0,0,0,1, 0,4,8'h01,8'hFF);
    r(8'h00,0,0,0,0, 1,0,8'h01,8'hFF);
    r(8'h00,0,0,1,0, 0,0,8'h00,8'hFF);
`endif
    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);
    // reset mid-handshake clears everything and restores the mask
    irq_in = 8'h40; mask_we = 1'b1; mask_wdata = 8'h00; int_ack = 1'b0; int_eoi = 1'b0;
    @(posedge clk); #1;
    irq_in = 8'h00; mask_we = 1'b0;
    chk("pre-reset pending", 32'(pending_o), 32'h40);
    chk("pre-reset mask", 32'(mask_o), 32'h00);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset mask", 32'(mask_o), 32'hFF);
    chk("midreset pending", 32'(pending_o), 32'h0);
    chk("midreset req", 32'(int_req), 32'h0);
    chk("midreset id", 32'(int_id), 32'h0);
    chk("midreset vector", 32'(int_vector), 32'h0010);
    irq_in = 8'h08;
    @(posedge clk); #1;
    irq_in = 8'h00;
    chk("post-reset early req", 32'(int_req), 32'h0);
    @(posedge clk); #1;
    chk("post-reset req", 32'(int_req), 32'h1);
    chk("post-reset id", 32'(int_id), 32'h3);
    chk("post-reset vector", 32'(int_vector), 32'h001C);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
